// File: rtl/tdm_demux.sv
// Time-division 1:NUM_CH demultiplexer with frame-alignment tracking and sync-error flagging.
// Optional build macro TDM_DEMUX_FRAME_ALIGN_EN: whole-frame output update via shadow registers.
module tdm_demux #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CH = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     IN_VALID,
  input  logic                     IN_SOF,
  input  logic [DATA_W-1:0]        IN_DATA,
  output logic [NUM_CH*DATA_W-1:0] OUT_DATA,
  output logic [NUM_CH-1:0]        OUT_VALID,
  output logic                     FRAME_DONE,
  output logic                     SYNC_ERR,
  output logic                     LOCKED
);

  localparam int unsigned CNT_W = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_CH - 1);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           slot_q, slot_d;
  logic [NUM_CH*DATA_W-1:0]   out_data_q;
  logic [NUM_CH-1:0]          out_valid_q;
  logic                       frame_done_q;
  logic                       sync_err_q;

  logic                       accept;
  logic [CNT_W-1:0]           acc_slot;
  logic                       err;
  logic                       last;

  always_comb begin
    accept   = 1'b0;
    acc_slot = '0;
    err      = 1'b0;
    state_d  = state_q;
    slot_d   = slot_q;
    if (IN_VALID) begin
      unique case (state_q)
        HUNT: begin
          if (IN_SOF) begin
            accept  = 1'b1;
            slot_d  = CNT_W'(1);
            state_d = LOCK;
          end
        end
        LOCK: begin
          if (IN_SOF == (slot_q == '0)) begin
            accept   = 1'b1;
            acc_slot = slot_q;
            slot_d   = (slot_q == LAST_SLOT) ? '0 : slot_q + CNT_W'(1);
          end else if (IN_SOF) begin
            // Early SOF: abandon the partial frame and restart with this word as slot 0.
            err    = 1'b1;
            accept = 1'b1;
            slot_d = CNT_W'(1);
          end else begin
            err     = 1'b1;
            slot_d  = '0;
            state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign last = accept && (acc_slot == LAST_SLOT);

`ifdef TDM_DEMUX_FRAME_ALIGN_EN
  logic [NUM_CH*DATA_W-1:0] shadow_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= HUNT;
      slot_q       <= '0;
      shadow_q     <= '0;
      out_data_q   <= '0;
      out_valid_q  <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      out_valid_q  <= '0;
      frame_done_q <= last;
      sync_err_q   <= err;
      if (err) shadow_q <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (accept && acc_slot == CNT_W'(k))
          shadow_q[k*DATA_W +: DATA_W] <= IN_DATA;
      end
      // Final slot bypasses the shadow so the whole frame publishes in one cycle.
      if (last) begin
        out_data_q <= shadow_q;
        out_data_q[(NUM_CH-1)*DATA_W +: DATA_W] <= IN_DATA;
        out_valid_q <= '1;
      end
    end
  end
`else
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= HUNT;
      slot_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      out_valid_q  <= '0;
      frame_done_q <= last;
      sync_err_q   <= err;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (accept && acc_slot == CNT_W'(k)) begin
          out_data_q[k*DATA_W +: DATA_W] <= IN_DATA;
          out_valid_q[k]                 <= 1'b1;
        end
      end
    end
  end
`endif

  assign OUT_DATA   = out_data_q;
  assign OUT_VALID  = out_valid_q;
  assign FRAME_DONE = frame_done_q;
  assign SYNC_ERR   = sync_err_q;
  assign LOCKED     = (state_q == LOCK);

endmodule
